// File: rtl/led_phy_tx.sv
// WS2812-style LED transmitter: pops 12-bit RGB words from a show-ahead FIFO and sends them as 24-bit GRB bits.
// Optional macro LED_PHY_UNDERRUN_CNT_EN adds the saturating underrun_cnt[7:0] output.
`timescale 1ns/1ps
module led_phy_tx #(
    parameter int TBIT         = 8,
    parameter int T0H          = 2,
    parameter int T1H          = 5,
    parameter int WORD_NUM     = 30,
    parameter int RESET_CYCLES = 400
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        send_start,
    input  logic        empty_flag,
    input  logic [11:0] fifo_dout,
    output logic        re,
    output logic        led_dout,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun
`ifdef LED_PHY_UNDERRUN_CNT_EN
    ,
    output logic [7:0]  underrun_cnt
`endif
);
    localparam int CYC_MAX = (TBIT > RESET_CYCLES) ? TBIT : RESET_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX);
    localparam int WC_W    = $clog2(WORD_NUM + 1);
    localparam logic [CYC_W-1:0] TBIT_LAST = CYC_W'(TBIT - 1);
    localparam logic [CYC_W-1:0] GAP_LAST  = CYC_W'(RESET_CYCLES - 1);
    localparam logic [CYC_W-1:0] T0H_C     = CYC_W'(T0H);
    localparam logic [CYC_W-1:0] T1H_C     = CYC_W'(T1H);
    localparam logic [WC_W-1:0]  WORD_LAST = WC_W'(WORD_NUM);

    typedef enum logic [2:0] {IDLE, WAIT, SEND, LATCH, DONE} state_t;

    state_t           state;
    logic             send_start_q;
    logic             start_p;
    logic [CYC_W-1:0] cyc;
    logic [4:0]       bit_cnt;
    logic [WC_W-1:0]  word_cnt;
    logic [23:0]      shreg;
    logic             word_end;
    logic             more_words;
    logic             pop;
    logic             urun_evt;

    function automatic logic [23:0] expand(input logic [11:0] w);
        return {w[7:4], w[7:4], w[11:8], w[11:8], w[3:0], w[3:0]};
    endfunction

    function automatic logic [CYC_W-1:0] high_time(input logic bit_val);
        return bit_val ? T1H_C : T0H_C;
    endfunction

    assign start_p    = send_start & ~send_start_q;
    assign word_end   = (state == SEND) && (cyc == TBIT_LAST) && (bit_cnt == 5'd23);
    assign more_words = (word_cnt != WORD_LAST);
    // Pop is combinational so the FIFO advances on the same edge that captures the head word.
    assign pop        = !empty_flag && ((state == WAIT) || (word_end && more_words));
    assign urun_evt   = word_end && more_words && empty_flag;
    assign re         = pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            send_start_q <= 1'b0;
            cyc          <= '0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            led_dout     <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            send_start_q <= send_start;
            frame_done   <= 1'b0;
            case (state)
                IDLE: if (start_p) begin
                    underrun <= 1'b0;
                    busy     <= 1'b1;
                    state    <= WAIT;
                end
                WAIT: if (pop) begin
                    cyc      <= '0;
                    bit_cnt  <= '0;
                    word_cnt <= WC_W'(1);
                    led_dout <= 1'b1;
                    state    <= SEND;
                end
                SEND: if (cyc == TBIT_LAST) begin
                    // Every bit starts high; words abut with no idle cycle between them.
                    cyc <= '0;
                    if (bit_cnt != 5'd23) begin
                        bit_cnt  <= bit_cnt + 5'd1;
                        led_dout <= 1'b1;
                    end else if (pop) begin
                        bit_cnt  <= '0;
                        word_cnt <= word_cnt + WC_W'(1);
                        led_dout <= 1'b1;
                    end else begin
                        underrun <= underrun | urun_evt;
                        led_dout <= 1'b0;
                        state    <= LATCH;
                    end
                end else begin
                    cyc      <= cyc + CYC_W'(1);
                    led_dout <= (cyc + CYC_W'(1)) < high_time(shreg[23]);
                end
                LATCH: if (cyc == GAP_LAST) begin
                    cyc        <= '0;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                    state      <= DONE;
                end else begin
                    cyc <= cyc + CYC_W'(1);
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pop)
            shreg <= expand(fifo_dout);
        else if ((state == SEND) && (cyc == TBIT_LAST))
            shreg <= {shreg[22:0], 1'b0};
    end

`ifdef LED_PHY_UNDERRUN_CNT_EN
    logic [7:0] urun_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            urun_cnt <= 8'h00;
        else if (urun_evt && (urun_cnt != 8'hFF))
            urun_cnt <= urun_cnt + 8'h01;
    end

    assign underrun_cnt = urun_cnt;
`endif

endmodule

// File: tb/tb_led_phy_tx.sv
// Bench for led_phy_tx: a FIFO model feeds the DUT; each frame is compared cycle by cycle against a waveform built from the word list.
`timescale 1ns/1ps
module tb_led_phy_tx;
    localparam int TBIT     = 8;
    localparam int T0H      = 2;
    localparam int T1H      = 5;
    localparam int WN       = 2;
    localparam int RC       = 20;
    localparam int WORD_CYC = 24 * TBIT;
    localparam int NEVER    = 100000;
    localparam int MAXS     = 1024;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        send_start = 1'b0;
    logic        empty_flag;
    logic [11:0] fifo_dout;
    logic        re, led_dout, busy, frame_done, underrun;
`ifdef LED_PHY_UNDERRUN_CNT_EN
    logic [7:0]  underrun_cnt;
    int          exp_cnt = 0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;

    logic s_led [MAXS];
    logic s_re  [MAXS];
    logic s_busy[MAXS];
    logic s_done[MAXS];
    logic e_led [MAXS];
    logic e_re  [MAXS];
    logic e_busy[MAXS];
    logic e_done[MAXS];

    typedef struct {
        logic [11:0] w0;
        logic [11:0] w1;
        int          k0;
        int          k1;
        int          toggle_at;
        bit          start_at_done;
        logic [23:0] grb0;
        logic [23:0] grb1;
        bit          exp_urun;
    } vec_t;
    vec_t tbl [6];

    always #5 clk = ~clk;

    assign empty_flag = (wr_ptr == rd_ptr);
    assign fifo_dout  = mem[rd_ptr[5:0]];
    always @(posedge clk) if (re && !empty_flag) rd_ptr <= rd_ptr + 1;

    led_phy_tx #(.TBIT(TBIT), .T0H(T0H), .T1H(T1H), .WORD_NUM(WN), .RESET_CYCLES(RC)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .send_start (send_start),
        .empty_flag (empty_flag),
        .fifo_dout  (fifo_dout),
        .re         (re),
        .led_dout   (led_dout),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
`ifdef LED_PHY_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    task automatic check(input string name, input int id, input logic [31:0] got,
                         input logic [31:0] exp, input int at);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s case %0d cycle %0d: got %0h expected %0h", name, id, at, got, exp);
        end
    endtask

    task automatic push(input logic [11:0] w);
        mem[wr_ptr[5:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    // Nibble replication as plain arithmetic: n * 17 == {n, n}.
    function automatic logic [23:0] grb_of(input logic [11:0] w);
        int r, g, b;
        r = int'(w[11:8]);
        g = int'(w[7:4]);
        b = int'(w[3:0]);
        return 24'((g * 17) * 65536 + (r * 17) * 256 + b * 17);
    endfunction

    task automatic run_frame(input int id, input logic [11:0] w0, input logic [11:0] w1,
                             input int k0, input int k1, input int tog, input bit sad,
                             input logic [23:0] g0, input logic [23:0] g1, input bit exp_urun);
        int r0, fe, dn, len, nw;
        int ml, mr, mb, md;
        bit second;
        logic urun_end;
        logic [23:0] g [2];
`ifdef LED_PHY_UNDERRUN_CNT_EN
        logic [7:0] cnt_end;
`endif
        g[0] = g0;
        g[1] = g1;
        urun_end = 1'b0;
        @(negedge clk);
        send_start = 1'b0;
        wr_ptr = rd_ptr;
        if (k0 < 0) push(w0);
        if (k1 < 0) push(w1);
        @(negedge clk);
        send_start = 1'b1;
        r0     = (k0 < 0) ? 0 : k0;
        second = (k1 <= r0 + WORD_CYC);
        nw     = second ? 2 : 1;
        fe     = r0 + nw * WORD_CYC;
        dn     = fe + RC + 1;
        len    = dn + 3;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k == k0) push(w0);
            if (k == k1) push(w1);
            if (k == 2) send_start = 1'b0;
            if (k == tog) send_start = 1'b1;
            if (k == tog + 3) send_start = 1'b0;
            if (sad && k == dn) send_start = 1'b1;
            #1;
            s_led[k]  = led_dout;
            s_re[k]   = re;
            s_busy[k] = busy;
            s_done[k] = frame_done;
            if (k == 0) check("urun_clear", id, 32'(underrun), 32'd0, k);
            if (k == dn) begin
                urun_end = underrun;
`ifdef LED_PHY_UNDERRUN_CNT_EN
                cnt_end = underrun_cnt;
`endif
            end
        end
        for (int k = 0; k < len; k++) begin
            e_led[k]  = 1'b0;
            e_re[k]   = (k == r0) || (second && k == r0 + WORD_CYC);
            e_busy[k] = (k < dn);
            e_done[k] = (k == dn);
            if (k > r0 && k <= fe) begin
                int j, w, b, c;
                logic bv;
                j  = k - r0 - 1;
                w  = j / WORD_CYC;
                b  = (j / TBIT) % 24;
                c  = j % TBIT;
                bv = g[w][23 - b];
                e_led[k] = (c < (bv ? T1H : T0H));
            end
        end
        ml = len - 1; mr = len - 1; mb = len - 1; md = len - 1;
        for (int k = len - 1; k >= 0; k--) begin
            if (s_led[k]  !== e_led[k])  ml = k;
            if (s_re[k]   !== e_re[k])   mr = k;
            if (s_busy[k] !== e_busy[k]) mb = k;
            if (s_done[k] !== e_done[k]) md = k;
        end
        check("led_dout", id, 32'(s_led[ml]), 32'(e_led[ml]), ml);
        check("re", id, 32'(s_re[mr]), 32'(e_re[mr]), mr);
        check("busy", id, 32'(s_busy[mb]), 32'(e_busy[mb]), mb);
        check("frame_done", id, 32'(s_done[md]), 32'(e_done[md]), md);
        check("underrun", id, 32'(urun_end), 32'(exp_urun), dn);
`ifdef LED_PHY_UNDERRUN_CNT_EN
        if (exp_urun && exp_cnt < 255) exp_cnt++;
        check("underrun_cnt", id, 32'(cnt_end), 32'(exp_cnt), dn);
`endif
    endtask

    initial begin
        tbl[0] = '{12'hF0A, 12'h123, -1, -1,    -1,  1'b0, 24'h00FFAA, 24'h221133, 1'b0};
        tbl[1] = '{12'hFFF, 12'h000, 15, 20,    -1,  1'b0, 24'hFFFFFF, 24'h000000, 1'b0};
        tbl[2] = '{12'h5A3, 12'h000, -1, NEVER, -1,  1'b0, 24'hAA5533, 24'h000000, 1'b1};
        tbl[3] = '{12'hC81, 12'h7E2, -1, -1,    100, 1'b1, 24'h88CC11, 24'hEE7722, 1'b0};
        tbl[4] = '{12'h0F0, 12'hABC, -1, 192,   -1,  1'b0, 24'hFF0000, 24'hBBAACC, 1'b0};
        tbl[5] = '{12'h111, 12'h222, -1, 193,   -1,  1'b0, 24'h111111, 24'h222222, 1'b1};
        for (int i = 0; i < 64; i++) mem[i] = 12'h000;

        repeat (3) @(negedge clk);
        check("rst_led", 0, 32'(led_dout), 32'd0, 0);
        check("rst_busy", 0, 32'(busy), 32'd0, 0);
        check("rst_done", 0, 32'(frame_done), 32'd0, 0);
        check("rst_urun", 0, 32'(underrun), 32'd0, 0);
        check("rst_re", 0, 32'(re), 32'd0, 0);
`ifdef LED_PHY_UNDERRUN_CNT_EN
        check("rst_cnt", 0, 32'(underrun_cnt), 32'd0, 0);
`endif
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_frame(i, tbl[i].w0, tbl[i].w1, tbl[i].k0, tbl[i].k1, tbl[i].toggle_at,
                      tbl[i].start_at_done, tbl[i].grb0, tbl[i].grb1, tbl[i].exp_urun);

        for (int i = 0; i < 10; i++) begin
            logic [11:0] w0, w1;
            int k0, k1, r0, mode, tog;
            bit sad;
            w0   = 12'($urandom);
            w1   = 12'($urandom);
            k0   = int'($urandom_range(0, 12)) - 1;
            r0   = (k0 < 0) ? 0 : k0;
            mode = int'($urandom_range(0, 3));
            case (mode)
                0:       k1 = k0;
                1:       k1 = r0 + int'($urandom_range(1, WORD_CYC));
                2:       k1 = r0 + WORD_CYC + 1 + int'($urandom_range(0, 5));
                default: k1 = NEVER;
            endcase
            tog = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 150)) : -1;
            sad = 1'($urandom_range(0, 1));
            run_frame(100 + i, w0, w1, k0, k1, tog, sad, grb_of(w0), grb_of(w1),
                      (k1 > r0 + WORD_CYC));
        end

        // Asynchronous reset in the middle of a high bit phase.
        @(negedge clk);
        send_start = 1'b0;
        wr_ptr = rd_ptr;
        push(12'hFFF);
        push(12'hFFF);
        @(negedge clk);
        send_start = 1'b1;
        repeat (43) @(negedge clk);
        #1;
        check("pre_rst_led", 200, 32'(led_dout), 32'd1, 42);
        check("pre_rst_busy", 200, 32'(busy), 32'd1, 42);
        #1 rstn = 1'b0;
        #1;
        check("async_rst_led", 200, 32'(led_dout), 32'd0, 42);
        check("async_rst_busy", 200, 32'(busy), 32'd0, 42);
        check("async_rst_re", 200, 32'(re), 32'd0, 42);
        @(negedge clk);
        send_start = 1'b0;
        wr_ptr = rd_ptr;
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", 201, 32'(busy), 32'd0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
